buttons_poll_master: RTL

- Avalon-MM read master that periodically polls the 7-bit push-button PIO slave and debounces the samples.
- Converts debounced changes into press/release events on a valid/ready stream.
- Sits beside the Nios-less datapath, so game logic gets button events without CPU polling or interrupts.
- Talks to the PIO as a standard Avalon-MM master; the PIO returns registered readdata with fixed latency.

---
 rtl/buttons_pkg.sv | 14 +
 rtl/btn_debounce.sv | 60 ++++++
 rtl/buttons_poll_master.sv | 139 +++++++++++++
 3 files changed

// File: rtl/buttons_pkg.sv
// Shared constants and types for the push-button poll master.
package buttons_pkg;

  localparam int          BTN_WIDTH    = 7;
  localparam logic [31:0] BTN_PIO_ADDR = 32'h0000_0000;

  typedef struct packed {
    logic [BTN_WIDTH-1:0] pressed;
    logic [BTN_WIDTH-1:0] released;
  } btn_evt_t;

  typedef enum logic [1:0] {IDLE, READ, LAT, CAPTURE} poll_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Accepts a sample strobe; commits a new button state after DEBOUNCE_COUNT identical samples.
// Event strobe is combinational in the sample cycle and cannot be stalled; the caller must absorb it.
module btn_debounce
  import buttons_pkg::*;
#(
  parameter int DEBOUNCE_COUNT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 smp_vld,
  input  logic [BTN_WIDTH-1:0] smp_dat,
  output logic [BTN_WIDTH-1:0] btn_state,
  output logic                 evt_vld,
  output btn_evt_t             evt_dat
);

  localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_COUNT);

  logic [BTN_WIDTH-1:0] cand_q, cand_d;
  logic [BTN_WIDTH-1:0] state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;

  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    evt_vld = 1'b0;
    evt_dat = '0;
    if (smp_vld) begin
      if (smp_dat != cand_q) begin
        cand_d = smp_dat;
        cnt_d  = 4'd1;
      end else if (cnt_q != DB_MAX) begin
        cnt_d = cnt_q + 4'd1;
      end
      // The freshly updated count decides, so DEBOUNCE_COUNT=1 accepts every sample at once.
      if (cnt_d == DB_MAX && cand_d != state_q) begin
        state_d          = cand_d;
        evt_vld          = 1'b1;
        evt_dat.pressed  = cand_d & ~state_q;
        evt_dat.released = ~cand_d & state_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q  <= '0;
      cnt_q   <= '0;
      state_q <= '0;
    end else begin
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign btn_state = state_q;

endmodule

// File: rtl/buttons_poll_master.sv
// Polls the button PIO over Avalon-MM and streams debounced press/release events; event lands 2+READ_LATENCY cycles after tick.
// A full, unconsumed event slot OR-merges new events and raises sticky overrun; reads stall on waitrequest.
module buttons_poll_master
  import buttons_pkg::*;
#(
  parameter int                WIDTH          = BTN_WIDTH,
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] BUTTON_ADDR    = ADDR_W'(BTN_PIO_ADDR),
  parameter int                POLL_PERIOD    = 50000,
  parameter int                READ_LATENCY   = 1,
  parameter int                DEBOUNCE_COUNT = 4,
  parameter bit                ACTIVE_LOW     = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [WIDTH-1:0]  evt_press,
  output logic [WIDTH-1:0]  evt_release,
  output logic [WIDTH-1:0]  btn_state,
  output logic              overrun,
  input  logic              overrun_clr
);

  localparam int                 TIMER_W    = $clog2(POLL_PERIOD);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_PERIOD - 1);
  localparam logic [1:0]         LAT_INIT   = 2'(READ_LATENCY - 1);

  logic [TIMER_W-1:0] timer_q, timer_d;
  poll_state_e        state_q, state_d;
  logic [1:0]         lat_q, lat_d;
  logic               read_q, read_d;
  btn_evt_t           slot_q, slot_d;
  logic               vld_q, vld_d;
  logic               ovr_q, ovr_d;

  logic               tick;
  logic               consume;
  logic [WIDTH-1:0]   smp_dat;
  logic               db_evt_vld;
  btn_evt_t           db_evt;
  logic               unused_rd_hi;

  assign tick         = (timer_q == TIMER_LAST);
  assign consume      = vld_q & evt_ready;
  assign smp_dat      = avm_readdata[WIDTH-1:0] ^ {WIDTH{ACTIVE_LOW}};
  assign unused_rd_hi = ^avm_readdata[31:WIDTH];

  btn_debounce #(
    .DEBOUNCE_COUNT (DEBOUNCE_COUNT)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .smp_vld   (state_q == CAPTURE),
    .smp_dat   (smp_dat),
    .btn_state (btn_state),
    .evt_vld   (db_evt_vld),
    .evt_dat   (db_evt)
  );

  always_comb begin
    timer_d = tick ? '0 : timer_q + TIMER_W'(1);
    state_d = state_q;
    lat_d   = lat_q;
    case (state_q)
      IDLE:    if (tick) state_d = READ;
      READ: begin
        if (!avm_waitrequest) begin
          if (LAT_INIT == 2'd0) begin
            state_d = CAPTURE;
          end else begin
            state_d = LAT;
            lat_d   = LAT_INIT;
          end
        end
      end
      LAT: begin
        lat_d = lat_q - 2'd1;
        if (lat_d == 2'd0) state_d = CAPTURE;
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    read_d = (state_d == READ);
  end

  // Event slot: load when free or draining this cycle, otherwise merge and flag.
  always_comb begin
    slot_d = slot_q;
    vld_d  = vld_q;
    ovr_d  = ovr_q;
    if (overrun_clr) ovr_d = 1'b0;
    if (db_evt_vld) begin
      if (!vld_q || consume) begin
        slot_d = db_evt;
        vld_d  = 1'b1;
      end else begin
        slot_d.pressed  = slot_q.pressed | db_evt.pressed;
        slot_d.released = slot_q.released | db_evt.released;
        ovr_d           = 1'b1;
      end
    end else if (consume) begin
      slot_d = '0;
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
      state_q <= IDLE;
      lat_q   <= '0;
      read_q  <= 1'b0;
      slot_q  <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      state_q <= state_d;
      lat_q   <= lat_d;
      read_q  <= read_d;
      slot_q  <= slot_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign avm_address = BUTTON_ADDR;
  assign avm_read    = read_q;
  assign evt_valid   = vld_q;
  assign evt_press   = slot_q.pressed;
  assign evt_release = slot_q.released;
  assign overrun     = ovr_q;

endmodule
